boot_ctrl_regs: RTL and testbench
=================================

# boot_ctrl_regs

Register-bus responder for the BOOTCTRL window (default `0x1000`–`0x1013`). It serves the host-side regbus writes and reads that configure the core's DRAM base and entry PC, and it owns the core reset. On START it runs a reset-pulse state machine, releases the core, then tracks run and halt status and a run-cycle counter that the host can poll. It sits between the host regbus decoder and the core's reset and boot-vector inputs.

## Interface
Parameters:
- `BASE_ADDR`, `16'h1000`, base of the register window
- `RST_CYCLES`, `16`, cycles `CPU_RESET` stays high in STARTING (≥1)
- `DRAMBASE_INIT`, `32'h0`, reset value of DRAMBASE
- `ENTRYPC_INIT`, `32'h0`, reset value of ENTRYPC

Ports:
- `ACLK` in 1: sole clock, rising edge
- `ARESET` in 1: reset, synchronous, active-high
- `WRADDR` in 16: write address
- `BYTEEN` in 4: write byte enables
- `WREN` in 1: write strobe, one cycle per write
- `WDATA` in 32: write data
- `RDADDR` in 16: read address
- `RDEN` in 1: read strobe
- `RDATA` out 32: registered read data
- `CORE_HALT` in 1: core reports completion (level)
- `CPU_RESET` out 1: active-high core reset
- `DRAM_BASE` out 32: current DRAMBASE register
- `ENTRY_PC` out 32: current ENTRYPC register

## Operation
Register map (offsets from `BASE_ADDR`):
- `+0x0` STATUS, read-only:
  - bit0 HOLD_RESET
  - bit1 RUNNING
  - bit2 STARTING
  - bit3 HALTED
  - bit4 WERR (sticky)
  - all other bits 0
- `+0x4` CTRL:
  - bit0 HOLD_RESET, level, read-back
  - bit1 START, write-1-pulse, reads 0
  - bit2 WERR_CLR, write-1-pulse, reads 0
  - only writes with `BYTEEN[0]` set have effect
- `+0x8` DRAMBASE, RW, per-byte enables.
- `+0xC` ENTRYPC, RW, per-byte enables.
- `+0x10` CYCLES, read-only: number of cycles spent in RUN since the last START.
- Unmapped reads return 0. Unmapped writes are dropped with no side effect.

State machine:
- **IDLE**: `CPU_RESET`=1.
  - START with new HOLD_RESET=0 → STARTING; counter loads `RST_CYCLES-1`; CYCLES clears.
- **STARTING**: `CPU_RESET`=1; counter decrements each cycle.
  - Counter at 0 → RUN.
- **RUN**: `CPU_RESET`=0; CYCLES increments each cycle and saturates at `0xFFFF_FFFF`.
  - `CORE_HALT`=1 → HALTED.
  - START → STARTING (restart).
- **HALTED**: `CPU_RESET`=1; CYCLES frozen.
  - START → STARTING.
- HOLD_RESET=1 (after reset, or written) forces IDLE from any state on the next edge. While HOLD_RESET=1, START is ignored.
- A write of HOLD_RESET=0 and START=1 in the same CTRL write (`0x2`) starts the core.

DRAMBASE/ENTRYPC writes:
- Accepted only in IDLE or HALTED.
- In STARTING or RUN the write is dropped and WERR is set.
- WERR_CLR clears WERR. If a WERR_CLR and a set happen in the same cycle, the set wins (cannot occur on a single bus; documented for completeness).

## Timing
- Reset values:
  - `RDATA`=0, `CPU_RESET`=1
  - HOLD_RESET=1, state IDLE
  - `DRAM_BASE`=`DRAMBASE_INIT`, `ENTRY_PC`=`ENTRYPC_INIT`
  - CYCLES=0, WERR=0
- A reset mid-operation returns to IDLE immediately on that edge.
- Write: register updates on the `ACLK` edge that samples `WREN`=1. Outputs reflect the new value the next cycle.
- START sampled at edge N:
  - state is STARTING from N+1.
  - `CPU_RESET` falls at edge N+`RST_CYCLES`+1.
  - RUNNING reads 1 from then.
- Read: `RDATA` is registered on the edge sampling `RDEN`=1 and holds until the next `RDEN`. No wait states.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- `CORE_HALT` sampled in RUN at edge N → HALTED and `CPU_RESET`=1 from N+1. CYCLES excludes cycle N+1 onward.
- `CORE_HALT` is ignored outside RUN.

## Structure
- Package `bootctrl_pkg` holds:
  - offset constants `BOOT_STATUS_OFS` (0x0), `BOOT_CTRL_OFS` (0x4), `BOOT_DRAMBASE_OFS` (0x8), `BOOT_ENTRYPC_OFS` (0xC), `BOOT_CYCLES_OFS` (0x10)
  - STATUS/CTRL bit-index constants
  - enum `boot_state_e` {IDLE, STARTING, RUN, HALTED}
- One sub-module, `boot_seq_fsm`: state register, pulse counter and CYCLES counter. It takes start/hold/halt strobes and is instantiated by `boot_ctrl_regs`, which handles decode and registers.

## Test plan
- Reset, then read STATUS → `0x0000_0001`; `CPU_RESET`=1; reading `+0x4` returns `0x1`.
- Write DRAMBASE=`0x2000_0000` (`BYTEEN` `0xF`), ENTRYPC=0, CTRL=`0x2` (`BYTEEN` `0x1`) → `CPU_RESET` low exactly 17 cycles after the CTRL write edge (`RST_CYCLES`=16); STATUS then reads `0x2`; `DRAM_BASE`=`0x2000_0000`.
- Write DRAMBASE with `BYTEEN`=`0x4` and `WDATA`=`0xAABB_CCDD` in IDLE (starting from 0) → DRAMBASE reads `0x00BB_0000`.
- In RUN, write ENTRYPC=`0x100` → ENTRYPC unchanged; STATUS=`0x12`. Then CTRL=`0x4` → STATUS=`0x2`.
- In RUN, assert `CORE_HALT` after exactly 1000 RUN cycles → STATUS=`0x8`, CYCLES=1000, `CPU_RESET`=1. Then CTRL=`0x2` → restart, CYCLES=0.
- In RUN, write CTRL=`0x3` → IDLE next cycle, `CPU_RESET`=1, START ignored. Assert `ARESET` during STARTING → IDLE and all registers back to reset values.

Source files
------------

// File: rtl/boot_ctrl_regs_pkg.sv
// Shared constants for the BOOTCTRL register window: register offsets,
// STATUS/CTRL bit positions, sequencer states and a byte-merge helper.
package bootctrl_pkg;

    localparam logic [15:0] BOOT_STATUS_OFS   = 16'h0000;
    localparam logic [15:0] BOOT_CTRL_OFS     = 16'h0004;
    localparam logic [15:0] BOOT_DRAMBASE_OFS = 16'h0008;
    localparam logic [15:0] BOOT_ENTRYPC_OFS  = 16'h000C;
    localparam logic [15:0] BOOT_CYCLES_OFS   = 16'h0010;

    localparam int unsigned ST_HOLD_BIT     = 0;
    localparam int unsigned ST_RUNNING_BIT  = 1;
    localparam int unsigned ST_STARTING_BIT = 2;
    localparam int unsigned ST_HALTED_BIT   = 3;
    localparam int unsigned ST_WERR_BIT     = 4;

    localparam int unsigned CTRL_HOLD_BIT     = 0;
    localparam int unsigned CTRL_START_BIT    = 1;
    localparam int unsigned CTRL_WERR_CLR_BIT = 2;

    typedef enum logic [1:0] {
        IDLE,
        STARTING,
        RUN,
        HALTED
    } boot_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/boot_ctrl_regs_if.sv
// Host register bus for the BOOTCTRL window: one write channel with byte
// enables and one read channel with registered read data.
interface boot_ctrl_regs_if;

    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;

    modport master (
        output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        input  RDATA
    );

    modport slave (
        input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        output RDATA
    );

endinterface

// File: rtl/boot_ctrl_regs_seq_fsm.sv
// Core boot sequencer: IDLE/STARTING/RUN/HALTED state, reset-pulse counter
// and saturating run-cycle counter.
module boot_seq_fsm
    import bootctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic        halt_i,
    output boot_state_e state_o,
    output logic [31:0] cycles_o
);

    localparam logic [15:0] CNT_LOAD = 16'(RST_CYCLES - 1);

    boot_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        unique case (state_q)
            IDLE: ;
            STARTING: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 16'd1;
            end
            RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
                if (halt_i)         state_d  = HALTED;
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
        // start is only ever raised with hold already released, so it wins
        if (start_i) begin
            state_d  = STARTING;
            cnt_d    = CNT_LOAD;
            cycles_d = '0;
        end else if (hold_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign state_o  = state_q;
    assign cycles_o = cycles_q;

endmodule

// File: rtl/boot_ctrl_regs.sv
// BOOTCTRL register responder: decodes host reads/writes, holds DRAMBASE,
// ENTRYPC, HOLD_RESET and WERR, and drives the core reset via boot_seq_fsm.
module boot_ctrl_regs
    import bootctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = 16'h1000,
    parameter int unsigned RST_CYCLES    = 16,
    parameter logic [31:0] DRAMBASE_INIT = 32'h0,
    parameter logic [31:0] ENTRYPC_INIT  = 32'h0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    boot_ctrl_regs_if.slave        bus,
    input  logic                   CORE_HALT,
    output logic                   CPU_RESET,
    output logic [31:0]            DRAM_BASE,
    output logic [31:0]            ENTRY_PC
);

    logic        hold_q, hold_d;
    logic        start_q, start_d;
    logic        werr_q, werr_d;
    logic [31:0] dram_base_q, dram_base_d;
    logic [31:0] entry_pc_q, entry_pc_d;
    logic [31:0] rdata_q, rdata_d;

    logic [15:0] wr_ofs, rd_ofs;
    logic        wr_locked, werr_set, werr_clr;
    logic [31:0] status, ctrl_rd;
    boot_state_e state;
    logic [31:0] cycles;

    assign wr_ofs    = bus.WRADDR - BASE_ADDR;
    assign rd_ofs    = bus.RDADDR - BASE_ADDR;
    assign wr_locked = (state == STARTING) || (state == RUN);

    always_comb begin
        hold_d      = hold_q;
        start_d     = 1'b0;
        dram_base_d = dram_base_q;
        entry_pc_d  = entry_pc_q;
        werr_set    = 1'b0;
        werr_clr    = 1'b0;
        if (bus.WREN) begin
            case (wr_ofs)
                BOOT_CTRL_OFS: if (bus.BYTEEN[0]) begin
                    hold_d   = bus.WDATA[CTRL_HOLD_BIT];
                    start_d  = bus.WDATA[CTRL_START_BIT] & ~bus.WDATA[CTRL_HOLD_BIT];
                    werr_clr = bus.WDATA[CTRL_WERR_CLR_BIT];
                end
                BOOT_DRAMBASE_OFS: begin
                    if (wr_locked) werr_set    = 1'b1;
                    else           dram_base_d = byte_merge(dram_base_q, bus.WDATA, bus.BYTEEN);
                end
                BOOT_ENTRYPC_OFS: begin
                    if (wr_locked) werr_set   = 1'b1;
                    else           entry_pc_d = byte_merge(entry_pc_q, bus.WDATA, bus.BYTEEN);
                end
                default: ;
            endcase
        end
        werr_d = werr_q;
        if (werr_clr) werr_d = 1'b0;
        if (werr_set) werr_d = 1'b1;
    end

    always_comb begin
        status                  = '0;
        status[ST_HOLD_BIT]     = hold_q;
        status[ST_RUNNING_BIT]  = (state == RUN);
        status[ST_STARTING_BIT] = (state == STARTING);
        status[ST_HALTED_BIT]   = (state == HALTED);
        status[ST_WERR_BIT]     = werr_q;
        ctrl_rd                 = '0;
        ctrl_rd[CTRL_HOLD_BIT]  = hold_q;
        rdata_d = rdata_q;
        if (bus.RDEN) begin
            case (rd_ofs)
                BOOT_STATUS_OFS:   rdata_d = status;
                BOOT_CTRL_OFS:     rdata_d = ctrl_rd;
                BOOT_DRAMBASE_OFS: rdata_d = dram_base_q;
                BOOT_ENTRYPC_OFS:  rdata_d = entry_pc_q;
                BOOT_CYCLES_OFS:   rdata_d = cycles;
                default:           rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            hold_q      <= 1'b1;
            start_q     <= 1'b0;
            werr_q      <= 1'b0;
            dram_base_q <= DRAMBASE_INIT;
            entry_pc_q  <= ENTRYPC_INIT;
            rdata_q     <= '0;
        end else begin
            hold_q      <= hold_d;
            start_q     <= start_d;
            werr_q      <= werr_d;
            dram_base_q <= dram_base_d;
            entry_pc_q  <= entry_pc_d;
            rdata_q     <= rdata_d;
        end
    end

    // START is staged one cycle so the sequencer enters STARTING on the edge after the CTRL write
    boot_seq_fsm #(
        .RST_CYCLES(RST_CYCLES)
    ) u_seq (
        .clk     (ACLK),
        .rst     (ARESET),
        .start_i (start_q),
        .hold_i  (hold_q),
        .halt_i  (CORE_HALT),
        .state_o (state),
        .cycles_o(cycles)
    );

    assign bus.RDATA = rdata_q;
    assign CPU_RESET = (state != RUN);
    assign DRAM_BASE = dram_base_q;
    assign ENTRY_PC  = entry_pc_q;

endmodule

// File: tb/tb_boot_ctrl_regs.sv
// Self-checking bench for boot_ctrl_regs: table of register accesses in IDLE,
// then hand-written start/run/halt/hold/reset sequences.
module tb_boot_ctrl_regs;

    localparam logic [31:0] EPC_INIT = 32'h0000_0400;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        CORE_HALT;
    logic        CPU_RESET;
    logic [31:0] DRAM_BASE;
    logic [31:0] ENTRY_PC;

    boot_ctrl_regs_if bus();

    boot_ctrl_regs #(
        .BASE_ADDR    (16'h1000),
        .RST_CYCLES   (16),
        .DRAMBASE_INIT(32'h0),
        .ENTRYPC_INIT (EPC_INIT)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .bus      (bus),
        .CORE_HALT(CORE_HALT),
        .CPU_RESET(CPU_RESET),
        .DRAM_BASE(DRAM_BASE),
        .ENTRY_PC (ENTRY_PC)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [15:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.be = be; v.data = data; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
        bus.WRADDR = addr;
        bus.BYTEEN = be;
        bus.WDATA  = data;
        bus.WREN   = 1'b1;
        @(posedge ACLK);
        #1;
        bus.WREN   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        e.exp  = exp;
        e.name = name;
        bus.RDADDR = addr;
        bus.RDEN   = 1'b1;
        sb_q.push_back(e);
        @(posedge ACLK);
        #1;
        bus.RDEN = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sb_q.pop_front();
            check(e.name, bus.RDATA, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;

        ARESET     = 1'b1;
        CORE_HALT  = 1'b0;
        bus.WRADDR = '0;
        bus.BYTEEN = '0;
        bus.WREN   = 1'b0;
        bus.WDATA  = '0;
        bus.RDADDR = '0;
        bus.RDEN   = 1'b0;
        wait_cycles(3);
        ARESET = 1'b0;

        check("cpu_reset_after_rst", {31'b0, CPU_RESET}, 32'h1);
        check("rdata_after_rst", bus.RDATA, 32'h0);
        check("dram_port_rst", DRAM_BASE, 32'h0);
        check("epc_port_rst", ENTRY_PC, EPC_INIT);

        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0001, "status_rst");
        add(0, 16'h1004, 4'h0, 32'h0,         32'h0000_0001, "ctrl_rst");
        add(0, 16'h1008, 4'h0, 32'h0,         32'h0000_0000, "dram_rst");
        add(0, 16'h100C, 4'h0, 32'h0,         EPC_INIT,      "epc_rst");
        add(0, 16'h1010, 4'h0, 32'h0,         32'h0000_0000, "cycles_rst");
        add(1, 16'h1008, 4'h4, 32'hAABB_CCDD, 32'h0,         "");
        add(0, 16'h1008, 4'h0, 32'h0,         32'h00BB_0000, "dram_be4");
        add(1, 16'h1008, 4'h3, 32'h1122_3344, 32'h0,         "");
        add(0, 16'h1008, 4'h0, 32'h0,         32'h00BB_3344, "dram_be3");
        add(1, 16'h1014, 4'hF, 32'hFFFF_FFFF, 32'h0,         "");
        add(0, 16'h1014, 4'h0, 32'h0,         32'h0000_0000, "unmapped_1014");
        add(0, 16'h0FFC, 4'h0, 32'h0,         32'h0000_0000, "unmapped_below");
        add(0, 16'h1008, 4'h0, 32'h0,         32'h00BB_3344, "dram_after_unmapped_wr");
        add(1, 16'h1004, 4'h2, 32'h0000_0002, 32'h0,         "");
        add(0, 16'h1004, 4'h0, 32'h0,         32'h0000_0001, "ctrl_no_be0");
        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0001, "status_no_be0");
        add(1, 16'h1004, 4'h1, 32'h0000_0003, 32'h0,         "");
        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0001, "status_start_hold");
        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0001, "status_start_hold2");
        add(1, 16'h1004, 4'h1, 32'h0000_0000, 32'h0,         "");
        add(0, 16'h1004, 4'h0, 32'h0,         32'h0000_0000, "ctrl_hold0");
        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0000, "status_hold0");
        add(1, 16'h100C, 4'hF, 32'h0000_0000, 32'h0,         "");
        add(0, 16'h100C, 4'h0, 32'h0,         32'h0000_0000, "epc_wr0");
        add(0, 16'h1002, 4'h0, 32'h0,         32'h0000_0000, "unaligned");
        add(0, 16'h1000, 4'h0, 32'h0,         32'h0000_0000, "status_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].be, vecs[i].data);
            else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // START: CPU_RESET must fall exactly 17 edges after the CTRL write edge
        wr(16'h1008, 4'hF, 32'h2000_0000);
        wr(16'h1004, 4'h1, 32'h0000_0002);
        check("cpu_reset_at_start_edge", {31'b0, CPU_RESET}, 32'h1);
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge ACLK);
            #1;
            if (CPU_RESET !== 1'b1) early++;
        end
        check("cpu_reset_held_16", early, 0);
        wait_cycles(1);
        check("cpu_reset_fall_n17", {31'b0, CPU_RESET}, 32'h0);
        check("dram_port_run", DRAM_BASE, 32'h2000_0000);
        check("epc_port_run", ENTRY_PC, 32'h0);
        rd(16'h1000, 32'h0000_0002, "status_running");

        // Locked write in RUN sets WERR, WERR_CLR clears it
        wr(16'h100C, 4'hF, 32'h0000_0100);
        rd(16'h100C, 32'h0000_0000, "epc_locked");
        rd(16'h1000, 32'h0000_0012, "status_werr");
        check("epc_port_locked", ENTRY_PC, 32'h0);
        wr(16'h1004, 4'h1, 32'h0000_0004);
        rd(16'h1000, 32'h0000_0002, "status_werr_clr");

        // Restart from RUN, halt sampled on the 1000th RUN edge
        wr(16'h1004, 4'h1, 32'h0000_0002);
        wait_cycles(1016);
        check("running_before_halt", {31'b0, CPU_RESET}, 32'h0);
        CORE_HALT = 1'b1;
        wait_cycles(1);
        CORE_HALT = 1'b0;
        check("cpu_reset_on_halt", {31'b0, CPU_RESET}, 32'h1);
        rd(16'h1000, 32'h0000_0008, "status_halted");
        rd(16'h1010, 32'd1000,      "cycles_1000");
        rd(16'h1010, 32'd1000,      "cycles_frozen");

        // HALTED accepts writes without WERR
        wr(16'h100C, 4'hF, 32'h0000_0100);
        rd(16'h100C, 32'h0000_0100, "epc_halted_wr");
        rd(16'h1000, 32'h0000_0008, "status_halted_no_werr");
        check("epc_port_halted", ENTRY_PC, 32'h0000_0100);

        // Restart from HALTED; CORE_HALT during STARTING is ignored
        wr(16'h1004, 4'h1, 32'h0000_0002);
        CORE_HALT = 1'b1;
        wait_cycles(1);
        rd(16'h1010, 32'h0000_0000, "cycles_cleared");
        rd(16'h1000, 32'h0000_0004, "status_starting");
        wait_cycles(10);
        CORE_HALT = 1'b0;
        wait_cycles(4);
        check("halt_ignored_starting", {31'b0, CPU_RESET}, 32'h0);

        // HOLD_RESET+START in RUN forces IDLE and the START is ignored
        wr(16'h1004, 4'h1, 32'h0000_0003);
        wait_cycles(1);
        check("hold_forces_idle", {31'b0, CPU_RESET}, 32'h1);
        wait_cycles(20);
        check("start_ignored_hold", {31'b0, CPU_RESET}, 32'h1);
        rd(16'h1000, 32'h0000_0001, "status_hold_idle");

        // Synchronous reset during STARTING restores everything
        wr(16'h1008, 4'hF, 32'h1234_5678);
        wr(16'h1004, 4'h1, 32'h0000_0002);
        wait_cycles(3);
        wr(16'h100C, 4'hF, 32'hDEAD_BEEF);
        rd(16'h1008, 32'h1234_5678, "dram_pre_reset");
        rd(16'h1000, 32'h0000_0014, "status_starting_werr");
        ARESET = 1'b1;
        wait_cycles(1);
        ARESET = 1'b0;
        check("cpu_reset_mid_rst", {31'b0, CPU_RESET}, 32'h1);
        check("rdata_mid_rst", bus.RDATA, 32'h0);
        check("dram_port_mid_rst", DRAM_BASE, 32'h0);
        check("epc_port_mid_rst", ENTRY_PC, EPC_INIT);
        rd(16'h1000, 32'h0000_0001, "status_after_mid_rst");
        rd(16'h1004, 32'h0000_0001, "ctrl_after_mid_rst");
        rd(16'h1010, 32'h0000_0000, "cycles_after_mid_rst");
        wait_cycles(20);
        check("idle_after_mid_rst", {31'b0, CPU_RESET}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
